// File: rtl/tlb_array.sv
// Fully-associative dual-page TLB held in flops: combinational search and read ports,
// plus synchronous write and INVTLB invalidate driven from the WB/CSR stage.
module tlb_array #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = 4
) (
  input  logic            clk,
  input  logic            resetn,
  // search port
  input  logic [18:0]     s_vppn,
  input  logic            s_va_bit12,
  input  logic [9:0]      s_asid,
  output logic            s_found,
  output logic [IDXW-1:0] s_index,
  output logic [19:0]     s_ppn,
  output logic [5:0]      s_ps,
  output logic [1:0]      s_plv,
  output logic [1:0]      s_mat,
  output logic            s_d,
  output logic            s_v,
  // write port
  input  logic            we,
  input  logic [IDXW-1:0] w_index,
  input  logic            w_e,
  input  logic [18:0]     w_vppn,
  input  logic [5:0]      w_ps,
  input  logic [9:0]      w_asid,
  input  logic            w_g,
  input  logic [19:0]     w_ppn0,
  input  logic [1:0]      w_plv0,
  input  logic [1:0]      w_mat0,
  input  logic            w_d0,
  input  logic            w_v0,
  input  logic [19:0]     w_ppn1,
  input  logic [1:0]      w_plv1,
  input  logic [1:0]      w_mat1,
  input  logic            w_d1,
  input  logic            w_v1,
  // read port
  input  logic [IDXW-1:0] r_index,
  output logic            r_e,
  output logic [18:0]     r_vppn,
  output logic [5:0]      r_ps,
  output logic [9:0]      r_asid,
  output logic            r_g,
  output logic [19:0]     r_ppn0,
  output logic [1:0]      r_plv0,
  output logic [1:0]      r_mat0,
  output logic            r_d0,
  output logic            r_v0,
  output logic [19:0]     r_ppn1,
  output logic [1:0]      r_plv1,
  output logic [1:0]      r_mat1,
  output logic            r_d1,
  output logic            r_v1,
  // invalidate port
  input  logic            inv_valid,
  input  logic [4:0]      inv_op,
  input  logic [9:0]      inv_asid,
  input  logic [18:0]     inv_vppn
);

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  tlb_entry_t entry_q [TLBNUM];
  tlb_entry_t entry_d [TLBNUM];

  logic [TLBNUM-1:0] s_match;
  logic [TLBNUM-1:0] inv_hit;
  logic              hit_found;
  logic [IDXW-1:0]   hit_idx;
  tlb_entry_t        hit_entry;
  logic              hit_odd;

  // A 2MB entry (PS=21) compares only VPPN[18:9]; any other PS value is treated as 4KB.
  function automatic logic va_match(input tlb_entry_t ent, input logic [18:0] va);
    if (ent.ps == 6'd21) begin
      return ent.vppn[18:9] == va[18:9];
    end
    return ent.vppn == va;
  endfunction

  always_comb begin
    for (int i = 0; i < TLBNUM; i++) begin
      s_match[i] = entry_q[i].e & (entry_q[i].g | (entry_q[i].asid == s_asid)) &
                   va_match(entry_q[i], s_vppn);
    end
  end

  // Scanning downwards lets the lowest matching index overwrite any higher one.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (s_match[i]) begin
        hit_found = 1'b1;
        hit_idx   = IDXW'(i);
      end
    end
  end

  assign hit_entry = entry_q[hit_idx];
  assign hit_odd   = (hit_entry.ps == 6'd21) ? s_vppn[8] : s_va_bit12;

  always_comb begin
    s_found = hit_found;
    s_index = '0;
    s_ppn   = '0;
    s_ps    = '0;
    s_plv   = '0;
    s_mat   = '0;
    s_d     = 1'b0;
    s_v     = 1'b0;
    if (hit_found) begin
      s_index = hit_idx;
      s_ps    = hit_entry.ps;
      s_ppn   = hit_odd ? hit_entry.ppn1 : hit_entry.ppn0;
      s_plv   = hit_odd ? hit_entry.plv1 : hit_entry.plv0;
      s_mat   = hit_odd ? hit_entry.mat1 : hit_entry.mat0;
      s_d     = hit_odd ? hit_entry.d1   : hit_entry.d0;
      s_v     = hit_odd ? hit_entry.v1   : hit_entry.v0;
    end
  end

  always_comb begin
    for (int i = 0; i < TLBNUM; i++) begin
      inv_hit[i] = 1'b0;
      if (inv_valid) begin
        case (inv_op)
          5'd0, 5'd1: inv_hit[i] = 1'b1;
          5'd2:       inv_hit[i] = entry_q[i].g;
          5'd3:       inv_hit[i] = ~entry_q[i].g;
          5'd4:       inv_hit[i] = ~entry_q[i].g & (entry_q[i].asid == inv_asid);
          5'd5:       inv_hit[i] = ~entry_q[i].g & (entry_q[i].asid == inv_asid) &
                                   va_match(entry_q[i], inv_vppn);
          5'd6:       inv_hit[i] = (entry_q[i].g | (entry_q[i].asid == inv_asid)) &
                                   va_match(entry_q[i], inv_vppn);
          default:    inv_hit[i] = 1'b0;
        endcase
      end
    end
  end

  // Invalidate first, then the write, so a same-cycle write fully defines its entry.
  always_comb begin
    for (int i = 0; i < TLBNUM; i++) begin
      entry_d[i] = entry_q[i];
      if (inv_hit[i]) begin
        entry_d[i].e = 1'b0;
      end
    end
    if (we) begin
      entry_d[w_index] = '{e: w_e, vppn: w_vppn, ps: w_ps, asid: w_asid, g: w_g,
                           ppn0: w_ppn0, plv0: w_plv0, mat0: w_mat0, d0: w_d0, v0: w_v0,
                           ppn1: w_ppn1, plv1: w_plv1, mat1: w_mat1, d1: w_d1, v1: w_v1};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < TLBNUM; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < TLBNUM; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  assign r_e    = entry_q[r_index].e;
  assign r_vppn = entry_q[r_index].vppn;
  assign r_ps   = entry_q[r_index].ps;
  assign r_asid = entry_q[r_index].asid;
  assign r_g    = entry_q[r_index].g;
  assign r_ppn0 = entry_q[r_index].ppn0;
  assign r_plv0 = entry_q[r_index].plv0;
  assign r_mat0 = entry_q[r_index].mat0;
  assign r_d0   = entry_q[r_index].d0;
  assign r_v0   = entry_q[r_index].v0;
  assign r_ppn1 = entry_q[r_index].ppn1;
  assign r_plv1 = entry_q[r_index].plv1;
  assign r_mat1 = entry_q[r_index].mat1;
  assign r_d1   = entry_q[r_index].d1;
  assign r_v1   = entry_q[r_index].v1;

endmodule

// File: tb/tb_tlb_array.sv
// Scoreboarded bench for tlb_array: each cycle's expected search/read results come from an
// array-of-entries reference model and are checked by an independent negedge monitor.
module tb_tlb_array;
  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } mEntry;

  typedef struct {
    int           kind;
    logic [127:0] val;
    string        name;
  } expItem;

  logic            clk = 1'b0;
  logic            resetn;
  logic [18:0]     sVppn;
  logic            sVaBit12;
  logic [9:0]      sAsid;
  logic            sFound;
  logic [IDXW-1:0] sIndex;
  logic [19:0]     sPpn;
  logic [5:0]      sPs;
  logic [1:0]      sPlv, sMat;
  logic            sD, sV;
  logic            wEn;
  logic [IDXW-1:0] wIndex;
  mEntry           wEnt;
  logic [IDXW-1:0] rIndex;
  logic            rE, rG, rD0, rV0, rD1, rV1;
  logic [18:0]     rVppn;
  logic [5:0]      rPs;
  logic [9:0]      rAsid;
  logic [19:0]     rPpn0, rPpn1;
  logic [1:0]      rPlv0, rMat0, rPlv1, rMat1;
  logic            invValid;
  logic [4:0]      invOp;
  logic [9:0]      invAsid;
  logic [18:0]     invVppn;

  mEntry  model [TLBNUM];
  expItem expQ[$];
  int     checks = 0;
  int     errors = 0;
  logic [18:0] vaPool [4];

  always #5 clk = ~clk;

  tlb_array #(.TLBNUM(TLBNUM), .IDXW(IDXW)) dut (
    .clk(clk), .resetn(resetn),
    .s_vppn(sVppn), .s_va_bit12(sVaBit12), .s_asid(sAsid),
    .s_found(sFound), .s_index(sIndex), .s_ppn(sPpn), .s_ps(sPs),
    .s_plv(sPlv), .s_mat(sMat), .s_d(sD), .s_v(sV),
    .we(wEn), .w_index(wIndex), .w_e(wEnt.e), .w_vppn(wEnt.vppn), .w_ps(wEnt.ps),
    .w_asid(wEnt.asid), .w_g(wEnt.g),
    .w_ppn0(wEnt.ppn0), .w_plv0(wEnt.plv0), .w_mat0(wEnt.mat0), .w_d0(wEnt.d0), .w_v0(wEnt.v0),
    .w_ppn1(wEnt.ppn1), .w_plv1(wEnt.plv1), .w_mat1(wEnt.mat1), .w_d1(wEnt.d1), .w_v1(wEnt.v1),
    .r_index(rIndex), .r_e(rE), .r_vppn(rVppn), .r_ps(rPs), .r_asid(rAsid), .r_g(rG),
    .r_ppn0(rPpn0), .r_plv0(rPlv0), .r_mat0(rMat0), .r_d0(rD0), .r_v0(rV0),
    .r_ppn1(rPpn1), .r_plv1(rPlv1), .r_mat1(rMat1), .r_d1(rD1), .r_v1(rV1),
    .inv_valid(invValid), .inv_op(invOp), .inv_asid(invAsid), .inv_vppn(invVppn)
  );

  // Reference model: a page hits when the VA agrees on the bits its page size covers.
  function automatic bit modelVaHit(input mEntry en, input logic [18:0] va);
    if (en.ps == 6'd21) return en.vppn[18:9] == va[18:9];
    return en.vppn == va;
  endfunction

  function automatic logic [127:0] modelSearch(input logic [18:0] va, input logic b12,
                                               input logic [9:0] asid);
    mEntry en;
    bit    odd;
    for (int i = 0; i < TLBNUM; i++) begin
      en = model[i];
      if (en.e && (en.g || en.asid == asid) && modelVaHit(en, va)) begin
        odd = (en.ps == 6'd21) ? va[8] : b12;
        if (odd)
          return 128'({1'b1, IDXW'(i), en.ppn1, en.ps, en.plv1, en.mat1, en.d1, en.v1});
        return 128'({1'b1, IDXW'(i), en.ppn0, en.ps, en.plv0, en.mat0, en.d0, en.v0});
      end
    end
    return 128'(0);
  endfunction

  function automatic logic [127:0] modelRead(input int idx);
    return 128'(model[idx]);
  endfunction

  function automatic void modelInvalidate(input logic [4:0] op, input logic [9:0] asid,
                                          input logic [18:0] va);
    bit kill;
    for (int i = 0; i < TLBNUM; i++) begin
      case (op)
        5'd0, 5'd1: kill = 1;
        5'd2: kill = model[i].g;
        5'd3: kill = !model[i].g;
        5'd4: kill = !model[i].g && model[i].asid == asid;
        5'd5: kill = !model[i].g && model[i].asid == asid && modelVaHit(model[i], va);
        5'd6: kill = (model[i].g || model[i].asid == asid) && modelVaHit(model[i], va);
        default: kill = 0;
      endcase
      if (kill) model[i].e = 1'b0;
    end
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < TLBNUM; i++) model[i] = '0;
  endfunction

  function automatic mEntry mkEntry(input logic e, input logic [18:0] vppn, input logic [5:0] ps,
                                    input logic [9:0] asid, input logic g,
                                    input logic [19:0] ppn0, input logic [19:0] ppn1);
    mEntry en;
    en = '{e: e, vppn: vppn, ps: ps, asid: asid, g: g,
           ppn0: ppn0, plv0: 2'd3, mat0: 2'd1, d0: 1'b0, v0: 1'b1,
           ppn1: ppn1, plv1: 2'd0, mat1: 2'd2, d1: 1'b1, v1: 1'b1};
    return en;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: drains the scoreboard each negedge against whatever the DUT presents.
  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      expItem it;
      logic [127:0] act;
      it = expQ.pop_front();
      if (it.kind == 0)
        act = 128'({sFound, sIndex, sPpn, sPs, sPlv, sMat, sD, sV});
      else
        act = 128'({rE, rVppn, rPs, rAsid, rG, rPpn0, rPlv0, rMat0, rD0, rV0,
                    rPpn1, rPlv1, rMat1, rD1, rV1});
      checkOutput(it.name, act, it.val);
    end
  end

  // One cycle of stimulus, entered and left at posedge+1; the model steps at the posedge.
  task automatic applyStimulus(input bit doWr, input int wIdx, input mEntry ent,
                               input bit doInv, input logic [4:0] op, input logic [9:0] ia,
                               input logic [18:0] iv, input logic [18:0] sv, input logic b12,
                               input logic [9:0] sa, input int rIdx, input string tag);
    expItem it;
    wEn      = doWr;
    wIndex   = IDXW'(wIdx);
    wEnt     = ent;
    invValid = doInv;
    invOp    = op;
    invAsid  = ia;
    invVppn  = iv;
    sVppn    = sv;
    sVaBit12 = b12;
    sAsid    = sa;
    rIndex   = IDXW'(rIdx);
    it.kind = 0; it.val = modelSearch(sv, b12, sa); it.name = {tag, "/search"};
    expQ.push_back(it);
    it.kind = 1; it.val = modelRead(rIdx); it.name = $sformatf("%s/read%0d", tag, rIdx);
    expQ.push_back(it);
    @(posedge clk);
    if (doInv) modelInvalidate(op, ia, iv);
    if (doWr) model[wIdx] = ent;
    #1;
    wEn      = 1'b0;
    invValid = 1'b0;
  endtask

  task automatic doSearch(input logic [18:0] sv, input logic b12, input logic [9:0] sa,
                          input int rIdx, input string tag);
    applyStimulus(0, 0, '0, 0, 5'd0, 10'd0, 19'd0, sv, b12, sa, rIdx, tag);
  endtask

  task automatic doWrite(input int idx, input mEntry ent, input string tag);
    applyStimulus(1, idx, ent, 0, 5'd0, 10'd0, 19'd0, 19'd0, 1'b0, 10'd0, idx, tag);
  endtask

  task automatic doInv(input logic [4:0] op, input logic [9:0] ia, input logic [18:0] iv,
                       input string tag);
    applyStimulus(0, 0, '0, 1, op, ia, iv, 19'd0, 1'b0, 10'd0, 0, tag);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    mEntry re;
    logic [18:0] sv;
    vaPool = '{19'h12345, 19'h40000, 19'h0ABCD, 19'h7FE00};
    resetn = 1'b0; wEn = 1'b0; wIndex = '0; wEnt = '0; invValid = 1'b0; invOp = '0;
    invAsid = '0; invVppn = '0; sVppn = '0; sVaBit12 = 1'b0; sAsid = '0; rIndex = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    doSearch(19'h00000, 1'b0, 10'h000, 3, "reset");

    doWrite(5, mkEntry(1, 19'h12345, 6'd12, 10'h001, 0, 20'hAAAAA, 20'hBBBBB), "w5");
    doSearch(19'h12345, 1'b1, 10'h001, 5, "odd4k");
    doSearch(19'h12345, 1'b0, 10'h001, 5, "even4k");
    doSearch(19'h12345, 1'b1, 10'h002, 5, "asidMiss");

    doWrite(2, mkEntry(1, 19'h40000, 6'd21, 10'h3FF, 1, 20'h11111, 20'h00200), "w2");
    doSearch(19'h401FF, 1'b0, 10'h155, 2, "huge");
    doSearch(19'h40000, 1'b1, 10'h000, 2, "hugeEven");

    doWrite(1, mkEntry(1, 19'h0ABCD, 6'd12, 10'h000, 1, 20'h01010, 20'h01011), "w1");
    doWrite(7, mkEntry(1, 19'h0ABCD, 6'd12, 10'h000, 1, 20'h07070, 20'h07071), "w7");
    doSearch(19'h0ABCD, 1'b0, 10'h000, 7, "priority");

    doInv(5'd4, 10'h001, 19'd0, "op4");
    doSearch(19'h12345, 1'b1, 10'h001, 5, "op4gone");
    doSearch(19'h401FF, 1'b1, 10'h001, 2, "op4kept");
    doInv(5'd2, 10'h000, 19'd0, "op2");
    doSearch(19'h40000, 1'b0, 10'h000, 2, "op2gone");
    doWrite(9, mkEntry(1, 19'h7FE00, 6'd12, 10'h004, 0, 20'h09090, 20'h09091), "w9");
    doInv(5'd7, 10'h004, 19'h7FE00, "op7");
    doSearch(19'h7FE00, 1'b0, 10'h004, 9, "op7kept");
    doInv(5'd5, 10'h004, 19'h7FE00, "op5");
    doSearch(19'h7FE00, 1'b0, 10'h004, 9, "op5gone");

    doWrite(3, mkEntry(1, 19'h0ABCD, 6'd12, 10'h000, 1, 20'h03030, 20'h03031), "w3");
    applyStimulus(1, 4, mkEntry(1, 19'h12000, 6'd12, 10'h00A, 0, 20'h04040, 20'h04041),
                  1, 5'd0, 10'd0, 19'd0, 19'h0ABCD, 1'b0, 10'h000, 3, "invWr");
    for (int i = 0; i < TLBNUM; i++) doSearch(19'h12000, 1'b1, 10'h00A, i, "afterInvWr");

    wEn = 1'b1; wIndex = IDXW'(6);
    wEnt = mkEntry(1, 19'h00006, 6'd12, 10'h000, 1, 20'h06060, 20'h06061);
    #1 resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1; wEn = 1'b0;
    modelReset();
    for (int i = 0; i < TLBNUM; i += 2) doSearch(19'h12000, 1'b1, 10'h00A, i, "midReset");

    for (int n = 0; n < 400; n++) begin
      re.e    = ($urandom_range(0, 3) != 0);
      re.vppn = vaPool[$urandom_range(0, 3)] ^ 19'($urandom_range(0, 1) * $urandom_range(0, 511));
      re.ps   = $urandom_range(0, 1) ? 6'd21 : 6'd12;
      re.asid = 10'($urandom_range(0, 2));
      re.g    = ($urandom_range(0, 3) == 0);
      re.ppn0 = 20'($urandom); re.plv0 = 2'($urandom); re.mat0 = 2'($urandom);
      re.d0   = 1'($urandom);  re.v0   = 1'($urandom);
      re.ppn1 = 20'($urandom); re.plv1 = 2'($urandom); re.mat1 = 2'($urandom);
      re.d1   = 1'($urandom);  re.v1   = 1'($urandom);
      sv = vaPool[$urandom_range(0, 3)] ^ 19'($urandom_range(0, 1) * $urandom_range(0, 511));
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, TLBNUM - 1), re,
                    $urandom_range(0, 9) == 0, 5'($urandom_range(0, 7)),
                    10'($urandom_range(0, 2)), vaPool[$urandom_range(0, 3)],
                    sv, 1'($urandom), 10'($urandom_range(0, 2)),
                    $urandom_range(0, TLBNUM - 1), "random");
    end

    repeat (3) @(negedge clk);
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
